// File: rtl/la_cmd_seq_if.sv
// SRAM command/response port between the LA command sequencer (master)
// and the SRAM test path (slave).
interface la_cmd_seq_if #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 32
);
  logic                 cmd_val;
  logic                 cmd_wr;
  logic [ADDR_BITS-1:0] cmd_adr;
  logic [DATA_BITS-1:0] cmd_dat;
  logic                 cmd_ack;
  logic                 rsp_val;
  logic [DATA_BITS-1:0] rsp_dat;

  modport master (
    output cmd_val, cmd_wr, cmd_adr, cmd_dat,
    input  cmd_ack, rsp_val, rsp_dat
  );

  modport slave (
    input  cmd_val, cmd_wr, cmd_adr, cmd_dat,
    output cmd_ack, rsp_val, rsp_dat
  );
endinterface

// File: rtl/la_cmd_seq.sv
// Logic-analyzer driven command sequencer: toggle-handshaked LA writes become
// single SRAM read/write transactions, with status and readback on la_data_out.
module la_cmd_seq #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oen,
  output logic [127:0] la_data_out,
  la_cmd_seq_if.master sram
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

  state_t               state;
  logic                 tgl_s1, tgl_s2, tgl_s3;
  logic                 clr_s1, clr_s2, clr_s3;
  logic                 cmd_evt, clr_evt, tmo_hit;
  logic [7:0]           tcnt;
  logic [DATA_BITS-1:0] rdata;
  logic [15:0]          cmd_count;
  logic                 busy, timeout_err, overrun, done_tgl;
  logic                 unused_la;

  assign cmd_evt   = tgl_s2 ^ tgl_s3;
  assign clr_evt   = clr_s2 & ~clr_s3;
  assign tmo_hit   = (tcnt == TO_LAST);
  assign unused_la = ^{la_data_in, la_oen};

  assign la_data_out = {64'd0, done_tgl, 12'd0, overrun, timeout_err, busy,
                        cmd_count, 32'(rdata)};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tgl_s1       <= 1'b0;
      tgl_s2       <= 1'b0;
      tgl_s3       <= 1'b0;
      clr_s1       <= 1'b0;
      clr_s2       <= 1'b0;
      clr_s3       <= 1'b0;
      sram.cmd_val <= 1'b0;
      sram.cmd_wr  <= 1'b0;
      sram.cmd_adr <= '0;
      sram.cmd_dat <= '0;
      tcnt         <= 8'd0;
      rdata        <= '0;
      cmd_count    <= 16'd0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
      done_tgl     <= 1'b0;
    end else begin
      // synchronizer and history stage for the toggle and clear bits
      tgl_s1 <= la_data_in[63] & la_oen[63];
      tgl_s2 <= tgl_s1;
      tgl_s3 <= tgl_s2;
      clr_s1 <= la_data_in[62] & la_oen[62];
      clr_s2 <= clr_s1;
      clr_s3 <= clr_s2;

      if (cmd_evt && state != IDLE) begin
        overrun <= 1'b1;
      end

      // transaction sequencing
      case (state)
        IDLE: begin
          if (cmd_evt) begin
            sram.cmd_wr  <= la_data_in[56];
            sram.cmd_adr <= la_data_in[32 +: ADDR_BITS];
            sram.cmd_dat <= la_data_in[DATA_BITS-1:0];
            sram.cmd_val <= 1'b1;
            busy         <= 1'b1;
            tcnt         <= 8'd0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt <= tcnt + 8'd1;
          if (sram.cmd_ack) begin
            sram.cmd_val <= 1'b0;
            state        <= sram.cmd_wr ? DONE : WAIT_RSP;
          end else if (tmo_hit) begin
            sram.cmd_val <= 1'b0;
            timeout_err  <= 1'b1;
            state        <= DONE;
          end
        end
        WAIT_RSP: begin
          tcnt <= tcnt + 8'd1;
          if (sram.rsp_val) begin
            rdata <= sram.rsp_dat;
            state <= DONE;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done_tgl  <= tgl_s3;
          cmd_count <= cmd_count + 16'd1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // a clear never aborts the in-flight command; a finishing one counts from zero
      if (clr_evt) begin
        cmd_count   <= (state == DONE) ? 16'd1 : 16'd0;
        timeout_err <= 1'b0;
        overrun     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_la_cmd_seq.sv
// Directed bench for la_cmd_seq: cycle-by-cycle comparison against a
// transaction-level model plus hand-computed literal expectations.
module tb_la_cmd_seq;
  localparam int AB = 6;
  localparam int DB = 32;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] la_data_in;
  logic [127:0] la_oen;
  logic [127:0] la_data_out;

  always #5 clk = ~clk;

  la_cmd_seq_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) sram ();

  la_cmd_seq #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .la_data_in (la_data_in),
    .la_oen     (la_oen),
    .la_data_out(la_data_out),
    .sram       (sram)
  );

  int checks   = 0;
  int failures = 0;
  bit armed    = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Transaction-level model: shadow synchronizer plus a command lifecycle
  logic [2:0]    m_tsh = 3'b0, m_csh = 3'b0;
  bit            m_wait_ack = 0, m_wait_rsp = 0, m_finish = 0;
  int            m_age = 0;
  bit            m_wr = 0;
  logic [AB-1:0] m_adr = '0;
  logic [DB-1:0] m_dat = '0, m_rdata = '0;
  logic [15:0]   m_count = 16'd0;
  bit            m_busy = 0, m_to = 0, m_ovr = 0, m_done = 0;

  task automatic model_step();
    bit ev, cl, fin;
    if (reset) begin
      m_tsh = 3'b0; m_csh = 3'b0;
      m_wait_ack = 0; m_wait_rsp = 0; m_finish = 0; m_age = 0;
      m_wr = 0; m_adr = '0; m_dat = '0; m_rdata = '0; m_count = 16'd0;
      m_busy = 0; m_to = 0; m_ovr = 0; m_done = 0;
      return;
    end
    ev  = (m_tsh[1] != m_tsh[2]);
    cl  = m_csh[1] && !m_csh[2];
    fin = m_finish;
    if (ev && (m_wait_ack || m_wait_rsp || m_finish)) m_ovr = 1;
    if (m_finish) begin
      m_finish = 0;
      m_busy   = 0;
      m_done   = m_tsh[2];
      m_count  = m_count + 16'd1;
    end else if (m_wait_ack || m_wait_rsp) begin
      if (m_wait_ack && sram.cmd_ack) begin
        m_wait_ack = 0;
        if (m_wr) m_finish = 1;
        else      m_wait_rsp = 1;
      end else if (m_wait_rsp && sram.rsp_val) begin
        m_rdata    = sram.rsp_dat;
        m_wait_rsp = 0;
        m_finish   = 1;
      end else if (m_age == TO - 1) begin
        m_to       = 1;
        m_wait_ack = 0;
        m_wait_rsp = 0;
        m_finish   = 1;
      end
      m_age++;
    end else if (ev) begin
      m_wr       = la_data_in[56];
      m_adr      = la_data_in[32 +: AB];
      m_dat      = la_data_in[DB-1:0];
      m_wait_ack = 1;
      m_age      = 0;
      m_busy     = 1;
    end
    if (cl) begin
      m_count = fin ? 16'd1 : 16'd0;
      m_to    = 0;
      m_ovr   = 0;
    end
    m_tsh = {m_tsh[1:0], la_data_in[63] & la_oen[63]};
    m_csh = {m_csh[1:0], la_data_in[62] & la_oen[62]};
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // cmd_val activity counters, sampled at the edge (pre-update values)
  int val_hi = 0, val_rises = 0;
  bit val_prev = 0;
  initial forever begin
    @(posedge clk);
    if (sram.cmd_val === 1'b1) val_hi++;
    if (sram.cmd_val === 1'b1 && !val_prev) val_rises++;
    val_prev = (sram.cmd_val === 1'b1);
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("cmd_val", sram.cmd_val, m_wait_ack);
      if (m_wait_ack) begin
        chk("cmd_wr", sram.cmd_wr, m_wr);
        chk("cmd_adr", sram.cmd_adr, m_adr);
        chk("cmd_dat", sram.cmd_dat, m_dat);
      end
      chk("la_data_out", la_data_out,
          {64'd0, m_done, 12'd0, m_ovr, m_to, m_busy, m_count, 32'(m_rdata)});
    end
  end

  // SRAM responder
  bit        ack_en  = 1;
  int        ack_dly = 0;
  int        rsp_dly = 1;
  bit [31:0] mem [64];
  initial begin
    int w, rcnt;
    bit sent;
    logic [AB-1:0] radr;
    w = 0; rcnt = 0; sent = 0; radr = '0;
    sram.cmd_ack = 1'b0;
    sram.rsp_val = 1'b0;
    sram.rsp_dat = '0;
    forever begin
      @(negedge clk);
      sram.cmd_ack = 1'b0;
      sram.rsp_val = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          sram.rsp_val = 1'b1;
          sram.rsp_dat = mem[radr];
        end
      end
      if (sram.cmd_val !== 1'b1 || reset) begin
        w = 0;
        sent = 0;
      end else if (ack_en && !sent) begin
        if (w >= ack_dly) begin
          sram.cmd_ack = 1'b1;
          sent = 1;
          if (sram.cmd_wr) mem[sram.cmd_adr] = sram.cmd_dat;
          else begin
            radr = sram.cmd_adr;
            rcnt = rsp_dly;
          end
        end else w++;
      end
    end
  end

  task automatic wait_cmd(input string tag, output int lat);
    lat = 0;
    while (sram.cmd_val !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (sram.cmd_val !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_cmd_wait actual=no_cmd_val required=cmd_val_within_30", tag);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (la_data_out[48] !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (la_data_out[48] !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_wait actual=busy required=idle_within_200", tag);
    end
  endtask

  initial begin
    int lat;
    reset      = 1'b1;
    la_data_in = '0;
    la_oen     = '1;
    repeat (2) @(negedge clk);
    armed = 1;
    chk("reset_lao", la_data_out, 128'd0);
    chk("reset_cmd_val", sram.cmd_val, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // write 0xDEADBEEF to 0x05, ack on the fourth cmd_val cycle
    ack_dly = 3;
    la_data_in[31:0]  = 32'hDEADBEEF;
    la_data_in[37:32] = 6'h05;
    la_data_in[56]    = 1'b1;
    la_data_in[63]    = 1'b1;
    val_hi = 0;
    wait_cmd("a", lat);
    chk("a_latency", lat, 3);
    wait_idle("a");
    chk("a_val_cycles", val_hi, 4);
    chk("a_lao", la_data_out, 128'h8000_0001_0000_0000);

    // read 0x05 with a second toggle landing in WAIT_RSP
    ack_dly = 0;
    rsp_dly = 8;
    la_data_in[56] = 1'b0;
    la_data_in[63] = 1'b0;
    val_rises = 0;
    wait_cmd("b", lat);
    chk("b_latency", lat, 3);
    repeat (2) @(negedge clk);
    la_data_in[63] = 1'b1;
    wait_idle("b");
    repeat (4) @(negedge clk);
    chk("b_val_pulses", val_rises, 1);
    chk("b_lao", la_data_out, 128'h8004_0002_DEAD_BEEF);

    // read 0x07 that is never acked
    ack_en = 0;
    la_data_in[37:32] = 6'h07;
    la_data_in[63]    = 1'b0;
    val_hi = 0;
    wait_cmd("c", lat);
    wait_idle("c");
    chk("c_val_cycles", val_hi, TO);
    chk("c_lao", la_data_out, 128'h0006_0003_DEAD_BEEF);

    // clear pulse with count=3 and both sticky flags set
    la_data_in[62] = 1'b1;
    repeat (5) @(negedge clk);
    la_data_in[62] = 1'b0;
    repeat (5) @(negedge clk);
    chk("d_lao", la_data_out, 128'h0000_0000_DEAD_BEEF);

    // toggle with its enable low must be ignored
    ack_en = 1;
    la_oen[63]     = 1'b0;
    la_data_in[63] = 1'b1;
    val_rises = 0;
    repeat (10) @(negedge clk);
    chk("e_val_pulses", val_rises, 0);
    chk("e_lao", la_data_out, 128'h0000_0000_DEAD_BEEF);
    la_data_in[63] = 1'b0;
    repeat (2) @(negedge clk);
    la_oen[63] = 1'b1;
    repeat (4) @(negedge clk);

    // reset while a write to 0x0A is being issued
    ack_en = 0;
    la_data_in[31:0]  = 32'h12345678;
    la_data_in[37:32] = 6'h0A;
    la_data_in[56]    = 1'b1;
    la_data_in[63]    = 1'b1;
    wait_cmd("f", lat);
    reset = 1'b1;
    @(negedge clk);
    chk("f_reset_cmd_val", sram.cmd_val, 1'b0);
    chk("f_reset_lao", la_data_out, 128'd0);
    reset   = 1'b0;
    ack_en  = 1;
    ack_dly = 1;
    wait_cmd("f2", lat);
    chk("f_latency", lat, 3);
    wait_idle("f2");
    chk("f_lao", la_data_out, 128'h8000_0001_0000_0000);

    ack_dly = 0;
    rsp_dly = 2;
    la_data_in[56] = 1'b0;
    la_data_in[63] = 1'b0;
    wait_cmd("g", lat);
    wait_idle("g");
    chk("g_lao", la_data_out, 128'h0000_0002_1234_5678);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
